// File: rtl/rv32_pkg.sv
// RV32I decode definitions shared by the decode stage and its immediate generator.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  // Base opcodes recognised by the decoder (insn[6:0]).
  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OPIMM  = 7'h13,
    OPC_STORE  = 7'h23,
    OPC_BRANCH = 7'h63,
    OPC_LUI    = 7'h37,
    OPC_AUIPC  = 7'h17,
    OPC_JAL    = 7'h6F,
    OPC_JALR   = 7'h67,
    OPC_OP     = 7'h33,
    OPC_FENCE  = 7'h0F,
    OPC_SYSTEM = 7'h73
  } opcode_e;

  // Immediate formats; IMM_NONE covers R-type, FENCE and illegal encodings.
  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_type_e;

  // Occupancy of the skid pair; bit 1 is main_v, bit 0 is skid_v.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b10,
    OCC_TWO   = 2'b11
  } occ_e;

  // Everything the execute stage sees for one entry.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } decoded_t;

  // Sign-extend a 12-bit field to XLEN.
  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  // Sign-extend a 13-bit field to XLEN.
  function automatic logic [XLEN-1:0] sext13(input logic [12:0] v);
    return {{19{v[12]}}, v};
  endfunction

  // Sign-extend a 21-bit field to XLEN.
  function automatic logic [XLEN-1:0] sext21(input logic [20:0] v);
    return {{11{v[20]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);

  // Fetch side
  logic [AWIDTH-1:0] pc_i;
  logic [DWIDTH-1:0] insn_i;
  logic              valid_i;
  logic              ready_o;
  logic              flush_i;

  // Execute side
  logic [AWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] insn_o;
  logic [6:0]        opcode_o;
  logic [4:0]        rd_o;
  logic [4:0]        rs1_o;
  logic [4:0]        rs2_o;
  logic [2:0]        funct3_o;
  logic [6:0]        funct7_o;
  logic [DWIDTH-1:0] imm_o;
  logic              illegal_o;
  logic              valid_o;
  logic              ready_i;

  // Decode stage view.
  modport slave (
    input  pc_i, insn_i, valid_i, flush_i, ready_i,
    output ready_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
           funct3_o, funct7_o, imm_o, illegal_o, valid_o
  );

  // Environment view (fetch driver plus execute sink).
  modport master (
    output pc_i, insn_i, valid_i, flush_i, ready_i,
    input  ready_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
           funct3_o, funct7_o, imm_o, illegal_o, valid_o
  );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator and legality check.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] insn_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       imm_type_o,
  output logic            illegal_o
);

  opcode_e opc_s;
  logic    opc_known_s;

  assign opc_s = opcode_e'(insn_i[6:0]);

  // Classify the opcode into an immediate format and flag unknown encodings.
  always_comb begin
    imm_type_o  = IMM_NONE;
    opc_known_s = 1'b1;
    illegal_o   = 1'b0;
    case (opc_s)
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: imm_type_o = IMM_I;
      OPC_STORE:                                 imm_type_o = IMM_S;
      OPC_BRANCH:                                imm_type_o = IMM_B;
      OPC_LUI, OPC_AUIPC:                        imm_type_o = IMM_U;
      OPC_JAL:                                   imm_type_o = IMM_J;
      OPC_OP, OPC_FENCE:                         imm_type_o = IMM_NONE;
      default: begin
        imm_type_o  = IMM_NONE;
        opc_known_s = 1'b0;
      end
    endcase
    // Compressed/16-bit encodings are not supported.
    if (insn_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
    end else begin
      illegal_o = ~opc_known_s;
    end
  end

  // Assemble the immediate; illegal encodings always yield zero.
  always_comb begin
    imm_o = {XLEN{1'b0}};
    if (illegal_o) begin
      imm_o = {XLEN{1'b0}};
    end else begin
      case (imm_type_o)
        IMM_I:   imm_o = sext12(insn_i[31:20]);
        IMM_S:   imm_o = sext12({insn_i[31:25], insn_i[11:7]});
        IMM_B:   imm_o = sext13({insn_i[31], insn_i[7], insn_i[30:25],
                                 insn_i[11:8], 1'b0});
        IMM_U:   imm_o = {insn_i[31:12], 12'h000};
        IMM_J:   imm_o = sext21({insn_i[31], insn_i[19:12], insn_i[20],
                                 insn_i[30:21], 1'b0});
        default: imm_o = {XLEN{1'b0}};
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Pipeline stage 2: decodes fetch entries and presents them registered to
// execute through a two-entry skid buffer (main + skid) with a registered ready.
module decode_stage
  import rv32_pkg::*;
#(
  parameter int AWIDTH = 32,  // only 32 supported
  parameter int DWIDTH = 32   // only 32 supported
) (
  input  logic           clk,
  input  logic           rst_n,  // asynchronous, active-low
  decode_stage_if.slave  bus
);

  logic [AWIDTH-1:0] pc_s;
  logic [DWIDTH-1:0] insn_s;
  logic [XLEN-1:0]   imm_s;
  imm_type_e         imm_type_s;
  logic              illegal_s;
  decoded_t          in_dec_s;

  occ_e              occ_q, occ_d;
  decoded_t          main_q, main_d;
  decoded_t          skid_q, skid_d;
  logic [1:0]        occ_bits_s;
  logic              main_v_s;
  logic              skid_v_s;
  logic              in_xfer_s;
  logic              out_xfer_s;

  assign pc_s   = bus.pc_i;
  assign insn_s = bus.insn_i;

  imm_gen u_imm_gen (
    .insn_i     (insn_s),
    .imm_o      (imm_s),
    .imm_type_o (imm_type_s),
    .illegal_o  (illegal_s)
  );

  // Decode the incoming fetch entry into the bundle held by main/skid.
  always_comb begin
    in_dec_s.pc      = pc_s;
    in_dec_s.insn    = insn_s;
    in_dec_s.opcode  = insn_s[6:0];
    in_dec_s.rd      = insn_s[11:7];
    in_dec_s.rs1     = insn_s[19:15];
    in_dec_s.rs2     = insn_s[24:20];
    in_dec_s.funct3  = insn_s[14:12];
    in_dec_s.funct7  = insn_s[31:25];
    in_dec_s.illegal = illegal_s;
    // Formats without an immediate carry zero regardless of generator output.
    if (imm_type_s == IMM_NONE) begin
      in_dec_s.imm = {XLEN{1'b0}};
    end else begin
      in_dec_s.imm = imm_s;
    end
  end

  assign occ_bits_s = occ_q;
  assign main_v_s   = occ_bits_s[1];
  assign skid_v_s   = occ_bits_s[0];
  assign in_xfer_s  = bus.valid_i & ~skid_v_s;
  assign out_xfer_s = main_v_s & bus.ready_i;

  // Occupancy next-state and entry movement; flush empties both slots.
  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (bus.flush_i) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (in_xfer_s) begin
            main_d = in_dec_s;
            occ_d  = OCC_ONE;
          end else begin
            occ_d  = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            main_d = in_dec_s;
            occ_d  = OCC_ONE;
          end else if (in_xfer_s) begin
            skid_d = in_dec_s;
            occ_d  = OCC_TWO;
          end else if (out_xfer_s) begin
            occ_d  = OCC_EMPTY;
          end else begin
            occ_d  = OCC_ONE;
          end
        end
        OCC_TWO: begin
          // Input is blocked here, so only the drain of main matters.
          if (out_xfer_s) begin
            main_d = skid_q;
            occ_d  = OCC_ONE;
          end else begin
            occ_d  = OCC_TWO;
          end
        end
        default: begin
          occ_d = OCC_EMPTY;
        end
      endcase
    end
  end

  // Occupancy and entry registers; reset drops everything and zeroes outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign bus.ready_o   = ~skid_v_s;
  assign bus.valid_o   = main_v_s;
  assign bus.pc_o      = main_q.pc;
  assign bus.insn_o    = main_q.insn;
  assign bus.opcode_o  = main_q.opcode;
  assign bus.rd_o      = main_q.rd;
  assign bus.rs1_o     = main_q.rs1;
  assign bus.rs2_o     = main_q.rs2;
  assign bus.funct3_o  = main_q.funct3;
  assign bus.funct7_o  = main_q.funct7;
  assign bus.imm_o     = main_q.imm;
  assign bus.illegal_o = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  decode_stage_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  decode_stage #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode vectors: instruction, immediate, illegal, rd, rs1 (hand-computed).
  logic [31:0] tbl_insn [10] = '{32'h00500093, 32'hFE000EE3, 32'h123452B7,
                                 32'h0020A423, 32'hFF9FF06F, 32'h00000000,
                                 32'h00000033, 32'hFFF00013, 32'hFFFFFFFF,
                                 32'h00500091};
  logic [31:0] tbl_imm  [10] = '{32'h00000005, 32'hFFFFFFFC, 32'h12345000,
                                 32'h00000008, 32'hFFFFFFF8, 32'h00000000,
                                 32'h00000000, 32'hFFFFFFFF, 32'h00000000,
                                 32'h00000000};
  logic        tbl_ill  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [4:0]  tbl_rd   [10] = '{5'd1, 5'd29, 5'd5, 5'd8, 5'd0,
                                 5'd0, 5'd0, 5'd0, 5'd31, 5'd1};
  logic [4:0]  tbl_rs1  [10] = '{5'd0, 5'd0, 5'd8, 5'd1, 5'd31,
                                 5'd0, 5'd0, 5'd0, 5'd31, 5'd0};

  logic [31:0] s_insn [4] = '{32'h00100093, 32'h00200113,
                              32'h00300193, 32'h00400213};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b1;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.pc_i    = 32'h0;
    bus.insn_i  = 32'h0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if (bus.valid_o !== 1'b0) begin
      n_miss++; $display("FAIL reset_valid: got %b want 0", bus.valid_o);
    end
    n_vec++;
    if (bus.ready_o !== 1'b1) begin
      n_miss++; $display("FAIL reset_ready: got %b want 1", bus.ready_o);
    end
    n_vec++;
    if ({bus.pc_o, bus.insn_o, bus.imm_o} !== 96'h0) begin
      n_miss++; $display("FAIL reset_data: pc %h insn %h imm %h want 0", bus.pc_o, bus.insn_o, bus.imm_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.pc_i    = 32'h0000_0100;
    bus.insn_i  = 32'h00500093;
    tick();
    bus.valid_i = 1'b0;
    n_vec++;
    if (bus.valid_o !== 1'b1) begin
      n_miss++; $display("FAIL addi_valid: got %b want 1", bus.valid_o);
    end
    n_vec++;
    if (bus.opcode_o !== 7'h13) begin
      n_miss++; $display("FAIL addi_opcode: got %h want 13", bus.opcode_o);
    end
    n_vec++;
    if (bus.rd_o !== 5'd1 || bus.rs1_o !== 5'd0 || bus.funct3_o !== 3'd0) begin
      n_miss++; $display("FAIL addi_regs: rd %0d rs1 %0d f3 %0d want 1 0 0", bus.rd_o, bus.rs1_o, bus.funct3_o);
    end
    n_vec++;
    if (bus.imm_o !== 32'h5 || bus.pc_o !== 32'h100) begin
      n_miss++; $display("FAIL addi_imm_pc: imm %h pc %h want 5 100", bus.imm_o, bus.pc_o);
    end
    tick();
    n_vec++;
    if (bus.valid_o !== 1'b0) begin
      n_miss++; $display("FAIL addi_drain: valid %b want 0", bus.valid_o);
    end
  endtask

  task automatic test_decode_table();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.valid_i = 1'b1;
      bus.pc_i    = 32'h1000 + 32'(i * 4);
      bus.insn_i  = tbl_insn[i];
      tick();
      n_vec++;
      if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h1000 + 32'(i * 4) || bus.insn_o !== tbl_insn[i]) begin
        n_miss++; $display("FAIL tbl%0d_entry: valid %b pc %h insn %h want 1 %h %h", i, bus.valid_o, bus.pc_o, bus.insn_o, 32'h1000 + 32'(i * 4), tbl_insn[i]);
      end
      n_vec++;
      if (bus.imm_o !== tbl_imm[i]) begin
        n_miss++; $display("FAIL tbl%0d_imm: got %h want %h", i, bus.imm_o, tbl_imm[i]);
      end
      n_vec++;
      if (bus.illegal_o !== tbl_ill[i]) begin
        n_miss++; $display("FAIL tbl%0d_illegal: got %b want %b", i, bus.illegal_o, tbl_ill[i]);
      end
      n_vec++;
      if (bus.rd_o !== tbl_rd[i] || bus.rs1_o !== tbl_rs1[i] || bus.opcode_o !== tbl_insn[i][6:0]) begin
        n_miss++; $display("FAIL tbl%0d_fields: rd %0d rs1 %0d op %h want %0d %0d %h", i, bus.rd_o, bus.rs1_o, bus.opcode_o, tbl_rd[i], tbl_rs1[i], tbl_insn[i][6:0]);
      end
      if (i == 3) begin
        n_vec++;
        if (bus.rs2_o !== 5'd2 || bus.funct3_o !== 3'd2 || bus.funct7_o !== 7'd0) begin
          n_miss++; $display("FAIL sw_fields: rs2 %0d f3 %0d f7 %h want 2 2 0", bus.rs2_o, bus.funct3_o, bus.funct7_o);
        end
      end
      if (i == 1) begin
        n_vec++;
        if (bus.funct7_o !== 7'h7F || bus.rs2_o !== 5'd0) begin
          n_miss++; $display("FAIL beq_fields: f7 %h rs2 %0d want 7f 0", bus.funct7_o, bus.rs2_o);
        end
      end
    end
    bus.valid_i = 1'b0;
    tick();
    n_vec++;
    if (bus.valid_o !== 1'b0) begin
      n_miss++; $display("FAIL tbl_drain: valid %b want 0", bus.valid_o);
    end
  endtask

  task automatic test_back_to_back();
    int          n_in;
    int          n_out;
    logic        in_acc;
    logic        out_acc;
    logic [31:0] o_pc;
    logic [31:0] o_insn;
    n_in  = 0;
    n_out = 0;
    bus.valid_i = 1'b1;
    bus.pc_i    = 32'h2000;
    bus.insn_i  = s_insn[0];
    for (int c = 0; c < 20 && n_out < 4; c++) begin
      bus.ready_i = (c >= 3);
      in_acc  = bus.valid_i && bus.ready_o;
      out_acc = bus.valid_o && bus.ready_i;
      o_pc    = bus.pc_o;
      o_insn  = bus.insn_o;
      tick();
      if (out_acc) begin
        n_vec++;
        if (n_out >= 4 || o_pc !== 32'h2000 + 32'(n_out * 4) || o_insn !== s_insn[n_out]) begin
          n_miss++; $display("FAIL stream_out%0d: pc %h insn %h want %h", n_out, o_pc, o_insn, 32'h2000 + 32'(n_out * 4));
        end
        n_out++;
      end
      if (in_acc) n_in++;
      if (c == 1) begin
        n_vec++;
        if (bus.ready_o !== 1'b0 || n_in != 2) begin
          n_miss++; $display("FAIL stream_full: ready %b accepts %0d want 0 2", bus.ready_o, n_in);
        end
      end
      if (c == 2) begin
        n_vec++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h2000 || bus.ready_o !== 1'b0) begin
          n_miss++; $display("FAIL stream_hold: valid %b pc %h ready %b want 1 2000 0", bus.valid_o, bus.pc_o, bus.ready_o);
        end
      end
      if (n_in < 4) begin
        bus.pc_i   = 32'h2000 + 32'(n_in * 4);
        bus.insn_i = s_insn[n_in];
      end else begin
        bus.valid_i = 1'b0;
      end
    end
    n_vec++;
    if (n_out != 4) begin
      n_miss++; $display("FAIL stream_count: got %0d outputs want 4", n_out);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    tick();
    n_vec++;
    if (bus.valid_o !== 1'b0) begin
      n_miss++; $display("FAIL stream_dup: valid %b pc %h want 0", bus.valid_o, bus.pc_o);
    end
  endtask

  task automatic test_flush();
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.pc_i    = 32'h3000;
    bus.insn_i  = 32'h00A00093;
    tick();
    bus.pc_i    = 32'h3004;
    tick();
    n_vec++;
    if (bus.ready_o !== 1'b0) begin
      n_miss++; $display("FAIL flush_pre_two: ready %b want 0", bus.ready_o);
    end
    bus.pc_i    = 32'h3008;
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    n_vec++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      n_miss++; $display("FAIL flush_two: valid %b ready %b want 0 1", bus.valid_o, bus.ready_o);
    end
    bus.ready_i = 1'b1;
    tick();
    tick();
    n_vec++;
    if (bus.valid_o !== 1'b0) begin
      n_miss++; $display("FAIL flush_ghost: valid %b pc %h want 0", bus.valid_o, bus.pc_o);
    end
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.pc_i    = 32'h3010;
    tick();
    bus.pc_i    = 32'h3014;
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    n_vec++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      n_miss++; $display("FAIL flush_one_in: valid %b ready %b want 0 1", bus.valid_o, bus.ready_o);
    end
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    bus.pc_i    = 32'h3018;
    bus.insn_i  = 32'h00000033;
    tick();
    bus.valid_i = 1'b0;
    n_vec++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h3018) begin
      n_miss++; $display("FAIL flush_resume: valid %b pc %h want 1 3018", bus.valid_o, bus.pc_o);
    end
    tick();
    n_vec++;
    if (bus.valid_o !== 1'b0) begin
      n_miss++; $display("FAIL flush_resume_drain: valid %b want 0", bus.valid_o);
    end
  endtask

  task automatic test_reset_mid();
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.pc_i    = 32'h4000;
    bus.insn_i  = 32'h00500093;
    tick();
    bus.pc_i    = 32'h4004;
    tick();
    bus.valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      n_miss++; $display("FAIL rstmid_async: valid %b ready %b want 0 1", bus.valid_o, bus.ready_o);
    end
    n_vec++;
    if ({bus.pc_o, bus.insn_o, bus.imm_o} !== 96'h0) begin
      n_miss++; $display("FAIL rstmid_data: pc %h insn %h imm %h want 0", bus.pc_o, bus.insn_o, bus.imm_o);
    end
    tick();
    rst_n       = 1'b1;
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.pc_i    = 32'h4010;
    bus.insn_i  = 32'h123452B7;
    tick();
    bus.valid_i = 1'b0;
    n_vec++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h4010 || bus.imm_o !== 32'h12345000 || bus.rd_o !== 5'd5) begin
      n_miss++; $display("FAIL rstmid_first: valid %b pc %h imm %h rd %0d want 1 4010 12345000 5", bus.valid_o, bus.pc_o, bus.imm_o, bus.rd_o);
    end
    tick();
    n_vec++;
    if (bus.valid_o !== 1'b0) begin
      n_miss++; $display("FAIL rstmid_stale: valid %b pc %h want 0", bus.valid_o, bus.pc_o);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    test_reset();
    test_addi();
    test_decode_table();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
